// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the 5-stage pipeline (ID stage).
// Resolves load-use hazards, taken-branch flushes and data-memory wait states.
// Optional build macro: HAZARD_PERF_EN enables the stall_cycles performance counter.
module hazard_stall_ctrl #(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned CNT_W             = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic             use_rs1,
    input  logic             use_rs2,
    input  logic [4:0]       rd_ex,
    input  logic             MemRead_ex,
    input  logic             branch_taken_ex,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic             pipe_hold,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int unsigned LU_CNT_W = 3;
    localparam logic [LU_CNT_W-1:0] LU_INIT = LU_CNT_W'(LOAD_STALL_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    state_t              state, state_n, eff_state;
    logic [LU_CNT_W-1:0] lu_cnt, lu_cnt_n;
    logic                lu, mw;

    // Hazard detection for the instruction currently in ID.
    always_comb begin
        lu = MemRead_ex && (rd_ex != 5'd0) &&
             ((use_rs1 && (rs1_id == rd_ex)) || (use_rs2 && (rs2_id == rd_ex)));
        mw = dmem_req && !dmem_ready;
    end

    // State and remaining load-use stall count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= RUN;
            lu_cnt <= '0;
        end else begin
            state  <= state_n;
            lu_cnt <= lu_cnt_n;
        end
    end

    // Next-state and Mealy output decode; mw > branch > load-use.
    always_comb begin
        state_n     = state;
        lu_cnt_n    = lu_cnt;
        eff_state   = state;
        PCWrite     = 1'b1;
        IFIDWrite   = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        pipe_hold   = 1'b0;

        // The cycle a memory wait ends behaves exactly like the state being resumed.
        if (state == MEM_WAIT) begin
            eff_state = (lu_cnt != '0) ? LU_STALL : RUN;
        end

        if (mw) begin
            pipe_hold = 1'b1;
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            state_n   = MEM_WAIT;
        end else if (branch_taken_ex) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            lu_cnt_n    = '0;
            state_n     = RUN;
        end else if (eff_state == LU_STALL) begin
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            idex_bubble = 1'b1;
            lu_cnt_n    = lu_cnt - LU_CNT_W'(1);
            state_n     = (lu_cnt == LU_CNT_W'(1)) ? RUN : LU_STALL;
        end else if (lu) begin
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            idex_bubble = 1'b1;
            if (LU_INIT != '0) begin
                lu_cnt_n = LU_INIT;
                state_n  = LU_STALL;
            end else begin
                state_n  = RUN;
            end
        end else begin
            state_n = RUN;
        end

        // Reset forces the pipe to a safe, flushed configuration.
        if (!reset_n) begin
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            idex_bubble = 1'b1;
            ifid_flush  = 1'b1;
            pipe_hold   = 1'b0;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] cnt_q;

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (!PCWrite && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign stall_cycles = cnt_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: one instance with 1-cycle and one with 3-cycle load stalls.
module tb_hazard_stall_ctrl;

`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // Output pattern {PCWrite, IFIDWrite, idex_bubble, ifid_flush, pipe_hold}
    localparam logic [4:0] R = 5'b00110;
    localparam logic [4:0] I = 5'b11000;
    localparam logic [4:0] S = 5'b00100;
    localparam logic [4:0] F = 5'b11110;
    localparam logic [4:0] H = 5'b00001;
    localparam int         N = -1;

    typedef struct {
        logic [4:0] e1;
        logic [4:0] e3;
        int         c1;
        int         c3;
    } exp_t;

    logic        clk = 1'b0;
    logic        rn1 = 1'b0;
    logic        rn3 = 1'b0;
    logic [4:0]  rs1_id = '0, rs2_id = '0, rd_ex = '0;
    logic        use_rs1 = 1'b0, use_rs2 = 1'b0, MemRead_ex = 1'b0;
    logic        branch_taken_ex = 1'b0, dmem_req = 1'b0, dmem_ready = 1'b0;

    logic        pc1, ifw1, bub1, fl1, hold1;
    logic        pc3, ifw3, bub3, fl3, hold3;
    logic [31:0] cnt1, cnt3;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(32)) dut1 (
        .clk(clk), .reset_n(rn1),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .use_rs1(use_rs1), .use_rs2(use_rs2),
        .rd_ex(rd_ex), .MemRead_ex(MemRead_ex), .branch_taken_ex(branch_taken_ex),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .PCWrite(pc1), .IFIDWrite(ifw1), .idex_bubble(bub1), .ifid_flush(fl1),
        .pipe_hold(hold1), .stall_cycles(cnt1)
    );

    hazard_stall_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(32)) dut3 (
        .clk(clk), .reset_n(rn3),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .use_rs1(use_rs1), .use_rs2(use_rs2),
        .rd_ex(rd_ex), .MemRead_ex(MemRead_ex), .branch_taken_ex(branch_taken_ex),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .PCWrite(pc3), .IFIDWrite(ifw3), .idex_bubble(bub3), .ifid_flush(fl3),
        .pipe_hold(hold3), .stall_cycles(cnt3)
    );

    // Monitor: compare the combinational outputs mid-cycle against the scoreboard.
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t        e;
            logic [4:0]  a1, a3;
            logic [31:0] ec;
            e  = q.pop_front();
            a1 = {pc1, ifw1, bub1, fl1, hold1};
            a3 = {pc3, ifw3, bub3, fl3, hold3};
            n_checks++;
            if (a1 !== e.e1) begin
                n_fail++;
                $display("FAIL ctrl_l1 t=%0t got=%b want=%b", $time, a1, e.e1);
            end
            n_checks++;
            if (a3 !== e.e3) begin
                n_fail++;
                $display("FAIL ctrl_l3 t=%0t got=%b want=%b", $time, a3, e.e3);
            end
            if (e.c1 >= 0) begin
                ec = PERF ? 32'(e.c1) : 32'd0;
                n_checks++;
                if (cnt1 !== ec) begin
                    n_fail++;
                    $display("FAIL cnt_l1 t=%0t got=%0d want=%0d", $time, cnt1, ec);
                end
            end
            if (e.c3 >= 0) begin
                ec = PERF ? 32'(e.c3) : 32'd0;
                n_checks++;
                if (cnt3 !== ec) begin
                    n_fail++;
                    $display("FAIL cnt_l3 t=%0t got=%0d want=%0d", $time, cnt3, ec);
                end
            end
        end
    end

    // Apply one cycle of stimulus just after the rising edge and queue its expectation.
    task automatic step(input logic r1n, input logic r3n,
                        input logic [4:0] r1, input logic [4:0] r2, input logic [1:0] u,
                        input logic [4:0] rd, input logic mr, input logic br,
                        input logic dq, input logic dr,
                        input logic [4:0] e1, input logic [4:0] e3,
                        input int c1, input int c3);
        exp_t e;
        @(posedge clk);
        #1;
        rn1 = r1n; rn3 = r3n;
        rs1_id = r1; rs2_id = r2; use_rs1 = u[1]; use_rs2 = u[0];
        rd_ex = rd; MemRead_ex = mr; branch_taken_ex = br;
        dmem_req = dq; dmem_ready = dr;
        e.e1 = e1; e.e3 = e3; e.c1 = c1; e.c3 = c3;
        q.push_back(e);
    endtask

    initial begin
        //   rn1 rn3 rs1 rs2 use  rd mr br dq dr   e1 e3  c1 c3
        // reset overrides a live hazard
        step(0, 0, 5, 7, 2'b11, 5, 1, 0, 0, 0,  R, R,  0, 0);
        // lw x5 ; add x6,x5,x7 -> one stall, then run
        step(1, 0, 5, 7, 2'b11, 5, 1, 0, 0, 0,  S, R,  0, N);
        step(1, 0, 5, 7, 2'b11, 0, 0, 0, 0, 0,  I, R,  1, N);
        // no stall: rd_ex=x0, MemRead_ex=0, source not used
        step(1, 0, 0, 7, 2'b10, 0, 1, 0, 0, 0,  I, R,  N, N);
        step(1, 0, 5, 7, 2'b11, 5, 0, 0, 0, 0,  I, R,  N, N);
        step(1, 0, 5, 7, 2'b01, 5, 1, 0, 0, 0,  I, R,  N, N);
        // memory wait four cycles, then complete
        step(1, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0,  H, R,  1, N);
        step(1, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0,  H, R,  2, N);
        step(1, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0,  H, R,  3, N);
        step(1, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0,  H, R,  4, N);
        step(1, 0, 0, 0, 2'b00, 0, 0, 0, 1, 1,  I, R,  5, N);
        step(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0,  I, R,  5, N);
        // rs2 hazard
        step(1, 0, 1, 9, 2'b01, 9, 1, 0, 0, 0,  S, R,  5, N);
        step(1, 0, 1, 9, 2'b01, 0, 0, 0, 0, 0,  I, R,  6, N);
        // mw with lu: hold only, lu re-evaluated after the wait
        step(1, 0, 5, 7, 2'b11, 5, 1, 0, 1, 0,  H, R,  6, N);
        step(1, 0, 5, 7, 2'b11, 5, 1, 0, 1, 1,  S, R,  7, N);
        step(1, 0, 5, 7, 2'b11, 0, 0, 0, 0, 0,  I, R,  8, N);
        // branch with lu: flush wins, no stall afterwards
        step(1, 0, 5, 7, 2'b11, 5, 1, 1, 0, 0,  F, R,  8, N);
        step(1, 0, 5, 7, 2'b11, 0, 0, 0, 0, 0,  I, R,  8, N);
        // 3-cycle load stall on dut3
        step(1, 1, 5, 7, 2'b11, 5, 1, 0, 0, 0,  S, S,  8, 0);
        step(1, 1, 5, 7, 2'b11, 0, 0, 0, 0, 0,  I, S,  9, N);
        step(1, 1, 5, 7, 2'b11, 0, 0, 0, 0, 0,  I, S,  9, N);
        step(1, 1, 5, 7, 2'b11, 0, 0, 0, 0, 0,  I, I,  9, 3);
        // branch in the 2nd stall cycle
        step(1, 1, 5, 7, 2'b11, 5, 1, 0, 0, 0,  S, S,  9, N);
        step(1, 1, 5, 7, 2'b11, 0, 0, 1, 0, 0,  F, F, 10, N);
        step(1, 1, 5, 7, 2'b11, 0, 0, 0, 0, 0,  I, I, 10, 4);
        // reset during LU_STALL
        step(1, 1, 5, 7, 2'b11, 5, 1, 0, 0, 0,  S, S, 10, N);
        step(1, 0, 5, 7, 2'b11, 0, 0, 0, 0, 0,  I, R, 11, 0);
        step(1, 1, 5, 7, 2'b11, 0, 0, 0, 0, 0,  I, I, 11, 0);
        step(1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0,  I, I, 11, 0);

        for (int i = 0; i < 10 && q.size() != 0; i++) begin
            @(posedge clk);
        end
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
